// File: rtl/code_reader.sv
// code_reader: read-side sequencer for the DigiLock 4x16-bit code memory.
// Walks memory slots 0..3 (registered read), compares each word against the
// matching 16-bit slice of a latched 64-bit attempt, and reports match/no-match.
// Optional lockout (fail counter + lock timer + LOCKED state) is compiled in
// when CODE_READER_LOCKOUT_EN is defined; otherwise locked is tied low.
//
// Handshake: start is a level request sampled on the rising edge while the
// sequencer is free (IDLE, or the DONE cycle when no lockout is triggering);
// done is a one-cycle strobe and match is valid while done=1 and held until
// the next accepted start. Requests arriving while busy or locked are dropped.
module code_reader #(
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] attempt,
  output logic [1:0]  mem_idx,
  output logic        mem_enable,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        locked
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DONE   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  // Exposed for checkers via hierarchical reference.
  state_t      state;
  state_t      state_next;

  logic [2:0]  rd_cnt;
  logic [63:0] attempt_q;
  logic        mismatch;
  logic        match_q;
  logic [15:0] cmp_word;
  logic        word_ne;
  logic        lock_trigger;
  logic        accept;

  // Latched word that lines up with the data returning this cycle
  // (data for slot rd_cnt-1 arrives while rd_cnt is presented).
  always_comb begin
    cmp_word = attempt_q[63:48];
    case (rd_cnt)
      3'd1:    cmp_word = attempt_q[15:0];
      3'd2:    cmp_word = attempt_q[31:16];
      3'd3:    cmp_word = attempt_q[47:32];
      default: cmp_word = attempt_q[63:48];
    endcase
  end

  assign word_ne = (mem_rdata != cmp_word);

`ifdef CODE_READER_LOCKOUT_EN
  localparam logic [4:0]  MAX_FAILS_W = 5'(MAX_FAILS);
  localparam logic [19:0] LOCK_LOAD   = 20'(LOCK_CYCLES - 1);

  logic [3:0]  fail_cnt;
  logic [19:0] lock_timer;

  // A failing result that brings the consecutive-fail count to MAX_FAILS locks.
  assign lock_trigger = (state == S_DONE) && !match_q &&
                        (({1'b0, fail_cnt} + 5'd1) == MAX_FAILS_W);

  // Fail counter and lock timer: updated in the DONE cycle, timer runs in LOCKED.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_cnt   <= 4'd0;
      lock_timer <= 20'd0;
    end else if (state == S_DONE) begin
      if (match_q) begin
        fail_cnt <= 4'd0;
      end else if (lock_trigger) begin
        fail_cnt   <= 4'd0;
        lock_timer <= LOCK_LOAD;
      end else begin
        fail_cnt <= fail_cnt + 4'd1;
      end
    end else if ((state == S_LOCKED) && (lock_timer != 20'd0)) begin
      lock_timer <= lock_timer - 20'd1;
    end
  end
`else
  assign lock_trigger = 1'b0;
`endif

  // The DONE cycle can take the next request so attempts run every 6 cycles.
  assign accept = start && ((state == S_IDLE) ||
                            ((state == S_DONE) && !lock_trigger));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Read datapath: latch attempt, step the slot counter, accumulate mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt    <= 3'd0;
      attempt_q <= 64'd0;
      mismatch  <= 1'b0;
      match_q   <= 1'b0;
    end else if (accept) begin
      attempt_q <= attempt;
      mismatch  <= 1'b0;
      rd_cnt    <= 3'd0;
      match_q   <= 1'b0;
    end else if (state == S_READ) begin
      rd_cnt <= rd_cnt + 3'd1;
      if (rd_cnt != 3'd0) mismatch <= mismatch | word_ne;
      if (rd_cnt == 3'd4) match_q  <= ~(mismatch | word_ne);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_READ;
      S_READ: if (rd_cnt == 3'd4) state_next = S_DONE;
      S_DONE: begin
        if (lock_trigger) state_next = S_LOCKED;
        else if (start)   state_next = S_READ;
        else              state_next = S_IDLE;
      end
`ifdef CODE_READER_LOCKOUT_EN
      S_LOCKED: if (lock_timer == 20'd0) state_next = S_IDLE;
`else
      S_LOCKED: state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and slot counter.
  always_comb begin
    mem_enable = 1'b0;
    mem_idx    = 2'd0;
    busy       = 1'b0;
    done       = 1'b0;
    locked     = 1'b0;
    case (state)
      S_READ: begin
        mem_enable = (rd_cnt <= 3'd3);
        mem_idx    = rd_cnt[1:0];
        busy       = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      S_LOCKED: locked = 1'b1;
      default: ;
    endcase
  end

  assign mem_wr = 1'b0;
  assign match  = match_q;

endmodule

// File: tb/tb_code_reader.sv
// Testbench for code_reader: registered-read memory model, directed attempts,
// expected-match queue, lockout sequence (when CODE_READER_LOCKOUT_EN is set)
// and mid-read reset abort.
module tb_code_reader;

  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 10;
  localparam logic [63:0] GOOD  = 64'h6002_00C3_0035_0021;
  localparam logic [63:0] BAD0  = 64'h6002_00C3_0035_0020;
  localparam logic [63:0] BAD3  = 64'h6003_00C3_0035_0021;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] attempt;
  logic [1:0]  mem_idx;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_rdata = 16'h0;
  logic        busy;
  logic        done;
  logic        match;
  logic        locked;

  logic [15:0] mem [4];
  logic [0:0]  exp_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Registered-read memory model.
  always @(posedge clk) begin
    if (mem_enable) mem_rdata <= mem[mem_idx];
  end

  code_reader #(
    .MAX_FAILS  (MAX_FAILS),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .attempt   (attempt),
    .mem_idx   (mem_idx),
    .mem_enable(mem_enable),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .locked    (locked)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idx"},    64'(mem_idx),    64'd0);
    check({tag, "_en"},     64'(mem_enable), 64'd0);
    check({tag, "_wr"},     64'(mem_wr),     64'd0);
    check({tag, "_busy"},   64'(busy),       64'd0);
    check({tag, "_done"},   64'(done),       64'd0);
    check({tag, "_match"},  64'(match),      64'd0);
    check({tag, "_locked"}, 64'(locked),     64'd0);
  endtask

  // ---------------- driver tasks ----------------
  // One attempt: start pulsed (or held through READ), slot sequence checked
  // cycle by cycle, result popped from the expected queue in the done cycle.
  task automatic run_attempt(input logic [63:0] a, input bit hold);
    logic [0:0] exp_m;
    @(negedge clk);
    start   = 1'b1;
    attempt = a;
    exp_q.push_back(1'(a == {mem[3], mem[2], mem[1], mem[0]}));
    @(posedge clk);                       // E0
    @(negedge clk);
    if (!hold) start = 1'b0;
    attempt = ~a;                         // must not affect the latched code
    for (int k = 0; k < 4; k++) begin
      check("rd_en",   64'(mem_enable), 64'd1);
      check("rd_idx",  64'(mem_idx),    64'(k));
      check("rd_wr",   64'(mem_wr),     64'd0);
      check("rd_busy", 64'(busy),       64'd1);
      check("rd_done", 64'(done),       64'd0);
      @(negedge clk);
    end
    check("rd4_en",   64'(mem_enable), 64'd0);
    check("rd4_done", 64'(done),       64'd0);
    check("rd4_busy", 64'(busy),       64'd1);
    start = 1'b0;
    @(negedge clk);                       // cycle after E0+5
    check("done_strobe", 64'(done), 64'd1);
    check("done_busy",   64'(busy), 64'd1);
    if (exp_q.size() == 0) begin
      check("exp_q_underflow", 64'd1, 64'd0);
    end else begin
      exp_m = exp_q.pop_front();
      check("match", 64'(match), 64'(exp_m));
    end
  endtask

  task automatic post_check(input logic exp_locked);
    @(negedge clk);
    check("post_done",   64'(done),   64'd0);
    check("post_busy",   64'(busy),   64'd0);
    check("post_locked", 64'(locked), 64'(exp_locked));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] a;
    int          n;
    mem[0] = 16'h0021; mem[1] = 16'h0035; mem[2] = 16'h00C3; mem[3] = 16'h6002;
    reset = 1'b1; start = 1'b0; attempt = 64'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Correct code, then check match is held after the done strobe.
    run_attempt(GOOD, 1'b0);
    post_check(1'b0);
    check("match_held", 64'(match), 64'd1);

    run_attempt(BAD0, 1'b0);  post_check(1'b0);
    run_attempt(GOOD, 1'b0);  post_check(1'b0);
    // Slot 3 only differs, start held through READ: exactly one done.
    run_attempt(BAD3, 1'b1);  post_check(1'b0);
    repeat (3) begin
      @(negedge clk);
      check("held_no_redo", 64'(done | busy), 64'd0);
    end
    run_attempt(GOOD, 1'b0);  post_check(1'b0);

    // Single random bit flips, each followed by a correct attempt.
    for (int i = 0; i < 6; i++) begin
      a = GOOD;
      n = $urandom_range(0, 63);
      a[n] = ~a[n];
      run_attempt(a, 1'b0);    post_check(1'b0);
      run_attempt(GOOD, 1'b0); post_check(1'b0);
    end

`ifdef CODE_READER_LOCKOUT_EN
    run_attempt(BAD0, 1'b0); post_check(1'b0);
    run_attempt(BAD3, 1'b0); post_check(1'b0);
    run_attempt(BAD0, 1'b0); post_check(1'b1);
    n = 1;
    start = 1'b1; attempt = GOOD;
    while (locked && n < LOCK_CYCLES + 10) begin
      @(negedge clk);
      check("lock_ignore", 64'(busy | done), 64'd0);
      if (locked) n++;
    end
    start = 1'b0;
    check("lock_len", 64'(n), 64'(LOCK_CYCLES));
    check("exp_q_lock", 64'(exp_q.size()), 64'd0);
    run_attempt(GOOD, 1'b0); post_check(1'b0);
    run_attempt(BAD0, 1'b0); post_check(1'b0);
    run_attempt(BAD3, 1'b0); post_check(1'b0);
    run_attempt(GOOD, 1'b0); post_check(1'b0);
    run_attempt(BAD0, 1'b0); post_check(1'b0);
    run_attempt(BAD3, 1'b0); post_check(1'b0);
`else
    run_attempt(BAD0, 1'b0); post_check(1'b0);
    run_attempt(BAD3, 1'b0); post_check(1'b0);
    run_attempt(BAD0, 1'b0); post_check(1'b0);
`endif

    // Reset during READ at rd_cnt=2 aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; attempt = GOOD;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_idx", 64'(mem_idx), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    run_attempt(GOOD, 1'b0); post_check(1'b0);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
